// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU / I/O memory port arbiter.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
package mem_arb_pkg;

   localparam int DEF_DATA_W = 18;
   localparam int DEF_ADDR_W = 13;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_IO  = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic logic other_owner(input logic owner);
      return (owner == OWNER_CPU) ? OWNER_IO : OWNER_CPU;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant select for the memory arbiter plus the registered owner of the port.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester not granted most recently.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic cpu_req,
   input  logic io_req,
   input  logic take,
   output logic pick,
   output logic owner
);

   always_comb begin
      pick = OWNER_CPU;
      if (io_req && !cpu_req)
         pick = OWNER_IO;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      else if (io_req && cpu_req)
         pick = other_owner(owner);
`endif
   end

   // Resetting to I/O makes the CPU the preferred winner of the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         owner <= OWNER_IO;
      else if (take)
         owner <= pick;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU datapath and the I/O engine.
// Build option MEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int MEM_LAT = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic              io_done,
   output logic [DATA_W-1:0] io_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read_en,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [3:0] LAT_INIT =
      (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

   state_t     state;
   logic [3:0] cnt;
   logic       we;
   logic       pick;
   logic       owner;
   logic       take;
   logic       finish;

   assign take   = (state == IDLE) && (cpu_req || io_req);
   assign finish = ((state == ACCESS) && (MEM_LAT == 0))
                || ((state == WAIT) && (cnt == 4'd0));

   mem_arb_pick u_pick (
      .clk     (clk),
      .rst     (rst),
      .cpu_req (cpu_req),
      .io_req  (io_req),
      .take    (take),
      .pick    (pick),
      .owner   (owner)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         we           <= 1'b0;
         cpu_gnt      <= 1'b0;
         io_gnt       <= 1'b0;
         cpu_done     <= 1'b0;
         io_done      <= 1'b0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         busy         <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_rdata    <= '0;
         io_rdata     <= '0;
      end else begin
         cpu_done     <= 1'b0;
         io_done      <= 1'b0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (take) begin
                  state <= ACCESS;
                  busy  <= 1'b1;
                  if (pick == OWNER_IO) begin
                     we           <= io_we;
                     mem_addr     <= io_addr;
                     mem_wdata    <= io_wdata;
                     io_gnt       <= 1'b1;
                     mem_write_en <= io_we;
                     mem_read_en  <= ~io_we;
                  end else begin
                     we           <= cpu_we;
                     mem_addr     <= cpu_addr;
                     mem_wdata    <= cpu_wdata;
                     cpu_gnt      <= 1'b1;
                     mem_write_en <= cpu_we;
                     mem_read_en  <= ~cpu_we;
                  end
               end
            end
            ACCESS: begin
               if (MEM_LAT > 0) begin
                  state <= WAIT;
                  cnt   <= LAT_INIT;
               end else begin
                  state <= DONE;
               end
            end
            WAIT: begin
               if (cnt == 4'd0)
                  state <= DONE;
               else
                  cnt <= cnt - 4'd1;
            end
            DONE: begin
               state   <= IDLE;
               busy    <= 1'b0;
               cpu_gnt <= 1'b0;
               io_gnt  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         // Read data is captured on the edge that enters DONE.
         if (finish) begin
            if (owner == OWNER_IO) begin
               io_done <= 1'b1;
               if (!we)
                  io_rdata <= mem_rdata;
            end else begin
               cpu_done <= 1'b1;
               if (!we)
                  cpu_rdata <= mem_rdata;
            end
         end
      end
   end

   a_one_strobe: assert property (@(posedge clk) disable iff (!rst)
      !(mem_read_en && mem_write_en));

   a_one_gnt: assert property (@(posedge clk) disable iff (!rst)
      !(cpu_gnt && io_gnt));

endmodule
